// File: rtl/tone_osc_bank.sv
// Bank of NUM_CH independent tone oscillators with fixed note duration.
// Optional square-wave output enabled by defining TONE_OSC_SQUARE_EN.
module tone_osc_bank #(
  parameter int N          = 8,
  parameter int NUM_CH     = 4,
  parameter int DUR_CYCLES = 10000000,
  parameter int DUR_W      = $clog2(DUR_CYCLES)
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic [NUM_CH*N-1:0] freq,
  input  logic [NUM_CH-1:0]   play,
  input  logic [NUM_CH-1:0]   stop,
  input  logic [NUM_CH-1:0]   sustain,
  output logic [NUM_CH-1:0]   at_max,
  output logic [NUM_CH-1:0]   active,
  output logic [NUM_CH-1:0]   done,
`ifdef TONE_OSC_SQUARE_EN
  output logic [NUM_CH-1:0]   square,
`endif
  output logic                any_active
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(DUR_CYCLES - 1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           st_q;
    logic [N-1:0]     per_q;
    logic [N-1:0]     cnt_q;
    logic [DUR_W-1:0] dur_q;
    logic             at_q;
    logic             done_q;
    logic             tick;
    logic             last;
    logic             expire;

    assign tick   = cnt_q >= per_q;
    assign last   = dur_q == DUR_LAST;
    assign expire = last && !sustain[c];

    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
        st_q   <= IDLE;
        per_q  <= '0;
        cnt_q  <= '0;
        dur_q  <= '0;
        at_q   <= 1'b0;
        done_q <= 1'b0;
      end else if (play[c]) begin
        st_q   <= RUN;
        per_q  <= freq[c*N +: N];
        cnt_q  <= '0;
        dur_q  <= '0;
        at_q   <= 1'b0;
        done_q <= 1'b0;
      end else if (stop[c]) begin
        st_q   <= IDLE;
        at_q   <= 1'b0;
        done_q <= 1'b0;
      end else if (st_q == RUN) begin
        cnt_q  <= tick ? '0 : cnt_q + N'(1);
        at_q   <= tick;
        done_q <= expire;
        // dur_q saturates at the last count while sustain holds the note
        if (!last) begin
          dur_q <= dur_q + DUR_W'(1);
        end
        if (expire) begin
          st_q <= IDLE;
        end
      end else begin
        at_q   <= 1'b0;
        done_q <= 1'b0;
      end
    end

    assign at_max[c] = at_q;
    assign active[c] = st_q == RUN;
    assign done[c]   = done_q;

`ifdef TONE_OSC_SQUARE_EN
    logic sq_q;

    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
        sq_q <= 1'b0;
      end else if (play[c] || stop[c]) begin
        sq_q <= 1'b0;
      end else if (st_q == RUN) begin
        if (expire) begin
          sq_q <= 1'b0;
        end else if (tick) begin
          sq_q <= ~sq_q;
        end
      end
    end

    assign square[c] = sq_q;
`endif
  end

  assign any_active = |active;

endmodule

// File: tb/tb_tone_osc_bank.sv
// Scoreboard bench for tone_osc_bank: NUM_CH=2, N=8, DUR_CYCLES=20.
// Expected outputs come from an age-since-play reference model.
module tb_tone_osc_bank;

  localparam int N   = 8;
  localparam int NCH = 2;
  localparam int DUR = 20;

  logic           clk;
  logic           nRst;
  logic [NCH*N-1:0] freq;
  logic [NCH-1:0] play;
  logic [NCH-1:0] stop;
  logic [NCH-1:0] sustain;
  logic [NCH-1:0] at_max;
  logic [NCH-1:0] active;
  logic [NCH-1:0] done;
  logic [NCH-1:0] square;
  logic           any_active;

  tone_osc_bank #(
    .N(N),
    .NUM_CH(NCH),
    .DUR_CYCLES(DUR)
  ) dut (
    .clk(clk),
    .nRst(nRst),
    .freq(freq),
    .play(play),
    .stop(stop),
    .sustain(sustain),
    .at_max(at_max),
    .active(active),
    .done(done),
`ifdef TONE_OSC_SQUARE_EN
    .square(square),
`endif
    .any_active(any_active)
  );

`ifndef TONE_OSC_SQUARE_EN
  assign square = '0;
`endif

  typedef struct packed {
    logic [NCH-1:0] at;
    logic [NCH-1:0] act;
    logic [NCH-1:0] dn;
    logic [NCH-1:0] sq;
    logic           any;
  } exp_t;

  exp_t q[$];
  int   ncmp;
  int   nerr;
  int   ncyc;

  bit   m_run [NCH];
  int   m_age [NCH];
  int   m_per [NCH];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [NCH-1:0] p,
                                 input logic [NCH-1:0] s,
                                 input logic [NCH-1:0] su,
                                 input logic [NCH*N-1:0] f);
    exp_t e;
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      if (p[c]) begin
        m_run[c] = 1'b1;
        m_age[c] = 0;
        m_per[c] = int'(f[c*N +: N]);
        e.act[c] = 1'b1;
      end else if (s[c]) begin
        m_run[c] = 1'b0;
      end else if (m_run[c]) begin
        m_age[c] = m_age[c] + 1;
        e.at[c] = (m_age[c] % (m_per[c] + 1)) == 0;
        if (m_age[c] >= DUR && !su[c]) begin
          m_run[c] = 1'b0;
          e.dn[c] = 1'b1;
        end else begin
          e.act[c] = 1'b1;
`ifdef TONE_OSC_SQUARE_EN
          e.sq[c] = ((m_age[c] / (m_per[c] + 1)) % 2) == 1;
`endif
        end
      end
    end
    e.any = |e.act;
    return e;
  endfunction

  task automatic cyc(input logic [NCH-1:0] p,
                     input logic [NCH-1:0] s,
                     input logic [NCH-1:0] su,
                     input logic [NCH*N-1:0] f);
    @(negedge clk);
    play    = p;
    stop    = s;
    sustain = su;
    freq    = f;
    q.push_back(model(p, s, su, f));
  endtask

  task automatic idle(input int n, input logic [NCH-1:0] su,
                      input logic [NCH*N-1:0] f);
    repeat (n) cyc('0, '0, su, f);
  endtask

  task automatic chk_zero(input string name);
    ncmp++;
    if ({at_max, active, done, square, any_active} != '0) begin
      nerr++;
      $display("FAIL %s: at=%b act=%b dn=%b sq=%b any=%b want all 0",
               name, at_max, active, done, square, any_active);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    play    = '0;
    stop    = '0;
    sustain = '0;
    #2 nRst = 1'b0;
    #1 chk_zero("async_reset");
    for (int c = 0; c < NCH; c++) m_run[c] = 1'b0;
    q.push_back('0);
    @(negedge clk);
    nRst = 1'b1;
    q.push_back(model('0, '0, '0, freq));
  endtask

  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        g = '{at: at_max, act: active, dn: done, sq: square, any: any_active};
        ncmp++;
        if (g != e) begin
          nerr++;
          $display("FAIL cyc%0d: got at=%b act=%b dn=%b sq=%b any=%b want at=%b act=%b dn=%b sq=%b any=%b",
                   ncyc, g.at, g.act, g.dn, g.sq, g.any,
                   e.at, e.act, e.dn, e.sq, e.any);
        end
      end
      ncyc++;
    end
  end

  initial begin
    logic [NCH-1:0]   p;
    logic [NCH-1:0]   s;
    logic [NCH-1:0]   su;
    logic [NCH*N-1:0] f;
    ncmp = 0;
    nerr = 0;
    ncyc = 0;
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 1'b0;
      m_age[c] = 0;
      m_per[c] = 0;
    end
    nRst    = 1'b0;
    play    = '0;
    stop    = '0;
    sustain = '0;
    freq    = '0;
    #1 chk_zero("reset_state");
    @(negedge clk);
    nRst = 1'b1;

    // basic note, period 3
    cyc(2'b01, '0, '0, 16'h0003);
    idle(24, '0, 16'h0003);
    // period zero
    cyc(2'b01, '0, '0, 16'h0000);
    idle(24, '0, 16'h0000);
    // retrigger at E10 with a new period
    cyc(2'b01, '0, '0, 16'h0005);
    idle(9, '0, 16'h0002);
    cyc(2'b01, '0, '0, 16'h0002);
    idle(25, '0, 16'h0007);
    // abort at E7, then play+stop together
    cyc(2'b01, '0, '0, 16'h0003);
    idle(6, '0, 16'h0003);
    cyc('0, 2'b01, '0, 16'h0003);
    idle(5, '0, 16'h0003);
    cyc(2'b01, 2'b01, '0, 16'h0002);
    idle(22, '0, 16'h0002);
    // stop while idle has no effect
    cyc('0, 2'b11, '0, 16'h0002);
    // sustain held past the normal duration
    cyc(2'b01, '0, 2'b01, 16'h0003);
    idle(40, 2'b01, 16'h0003);
    idle(6, '0, 16'h0003);
    // two channels together, then async reset mid-note
    cyc(2'b11, '0, '0, 16'h0401);
    idle(10, '0, 16'h0401);
    do_reset();
    idle(25, '0, 16'h0401);
    // staggered channels
    cyc(2'b10, '0, '0, 16'h0200);
    idle(8, '0, 16'h0200);
    cyc(2'b01, '0, '0, 16'h0200);
    idle(30, '0, 16'h0200);

    su = '0;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        p[c] = $urandom_range(0, 29) == 0;
        s[c] = $urandom_range(0, 59) == 0;
        if ($urandom_range(0, 24) == 0) su[c] = ~su[c];
      end
      f = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
      if (i == 1000) do_reset();
      cyc(p, s, su, f);
    end
    idle(3, '0, '0);

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
